// File: rtl/disp_pkg.sv
// Shared constants and pixel layout for the display pixel buffer.
// Used by disp_fifo and disp_buffer.
package disp_pkg;

    localparam int DEPTH_LOG2_DEF  = 9;
    localparam int BURST_BEATS_DEF = 64;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    localparam int PIX_W = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic pixel_t beat_to_pixel(input logic [31:0] beat);
        pixel_t p;
        p.r = beat[R_MSB:R_LSB];
        p.g = beat[G_MSB:G_LSB];
        p.b = beat[B_MSB:B_LSB];
        return p;
    endfunction

endpackage

// File: rtl/disp_fifo.sv
// Single-clock FIFO with occupancy counter and registered RAM read port.
// Storage has no reset so it maps onto block RAM.
module disp_fifo
    import disp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int WIDTH      = PIX_W
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic                  flush,
    input  logic                  we,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;

    always_ff @(posedge ACLK) begin
        if (we)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge ACLK) begin
        if (re)
            rdata <= mem[rptr];
    end

    always_ff @(posedge ACLK) begin
        if (!ARST || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (we)
                wptr <= wptr + 1'b1;
            if (re)
                rptr <= rptr + 1'b1;
            count <= count + CW'(we) - CW'(re);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/disp_buffer.sv
// Pixel buffer between the VRAM read channel and the display output stage.
// Define DISP_BUF_STAT_EN to add the BUF_UFCNT underflow-cycle counter.
module disp_buffer
    import disp_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int BURST_BEATS = BURST_BEATS_DEF
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic [31:0] RDATA,
    input  logic        RVALID,
    input  logic        RREADY,
    input  logic        VRSTART,
    input  logic        DISPON,
    input  logic        DSP_PREN,
    output logic [7:0]  DSP_R,
    output logic [7:0]  DSP_G,
    output logic [7:0]  DSP_B,
    output logic        BUF_WREADY,
    output logic        BUF_UNDERFLOW,
    output logic        BUF_OVERFLOW
`ifdef DISP_BUF_STAT_EN
    ,
    output logic [15:0] BUF_UFCNT
`endif
);

    localparam int             CW      = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0]  BURST_C = CW'(BURST_BEATS);

    logic          wr_req;
    logic          we;
    logic          re;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [23:0]   rdata;
    logic          show;
    pixel_t        pix;
    logic          unused_xbyte;

    assign unused_xbyte = ^RDATA[31:24];

    assign wr_req = RVALID & RREADY;
    // Frame-start flush wins over any beat or pop in the same cycle.
    assign we = wr_req & ~full & ~VRSTART;
    assign re = DSP_PREN & ~empty & ~VRSTART;

    assign count_next = count + CW'(we) - CW'(re);

    disp_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (PIX_W)
    ) u_fifo (
        .ACLK  (ACLK),
        .ARST  (ARST),
        .flush (VRSTART),
        .we    (we),
        .wdata (beat_to_pixel(RDATA)),
        .re    (re),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge ACLK) begin
        if (!ARST || VRSTART) begin
            show          <= 1'b0;
            BUF_WREADY    <= 1'b1;
            BUF_UNDERFLOW <= 1'b0;
            BUF_OVERFLOW  <= 1'b0;
        end else begin
            show       <= re & DISPON;
            BUF_WREADY <= (DEPTH_C - count_next) >= BURST_C;
            if (DSP_PREN & empty)
                BUF_UNDERFLOW <= 1'b1;
            if (wr_req & full)
                BUF_OVERFLOW <= 1'b1;
        end
    end

`ifdef DISP_BUF_STAT_EN
    always_ff @(posedge ACLK) begin
        if (!ARST || VRSTART)
            BUF_UFCNT <= '0;
        else if (DSP_PREN & empty & (BUF_UFCNT != 16'hFFFF))
            BUF_UFCNT <= BUF_UFCNT + 16'd1;
    end
`endif

    // RAM read data is only shown in the cycle after a successful visible pop.
    assign pix   = pixel_t'(rdata);
    assign DSP_R = show ? pix.r : 8'h00;
    assign DSP_G = show ? pix.g : 8'h00;
    assign DSP_B = show ? pix.b : 8'h00;

endmodule

// File: tb/tb_disp_buffer.sv
// Self-checking bench for disp_buffer: queue-based reference model plus
// directed scenarios and randomized traffic.
module tb_disp_buffer;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b0;
    logic [31:0] RDATA = '0;
    logic        RVALID = 1'b0;
    logic        RREADY = 1'b0;
    logic        VRSTART = 1'b0;
    logic        DISPON = 1'b0;
    logic        DSP_PREN = 1'b0;
    logic [7:0]  DSP_R;
    logic [7:0]  DSP_G;
    logic [7:0]  DSP_B;
    logic        BUF_WREADY;
    logic        BUF_UNDERFLOW;
    logic        BUF_OVERFLOW;
`ifdef DISP_BUF_STAT_EN
    logic [15:0] BUF_UFCNT;
`endif

    always #5 ACLK = ~ACLK;

    disp_buffer dut (
        .ACLK          (ACLK),
        .ARST          (ARST),
        .RDATA         (RDATA),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .VRSTART       (VRSTART),
        .DISPON        (DISPON),
        .DSP_PREN      (DSP_PREN),
        .DSP_R         (DSP_R),
        .DSP_G         (DSP_G),
        .DSP_B         (DSP_B),
        .BUF_WREADY    (BUF_WREADY),
        .BUF_UNDERFLOW (BUF_UNDERFLOW),
        .BUF_OVERFLOW  (BUF_OVERFLOW)
`ifdef DISP_BUF_STAT_EN
        ,
        .BUF_UFCNT     (BUF_UFCNT)
`endif
    );

    localparam int DEPTH = 512;
    localparam int BURST = 64;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    bit          m_uf;
    bit          m_of;
    bit          m_wr;
    logic [23:0] m_pix;
    int          m_ufcnt;
    bit          live = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, then advance the reference model by the same edge.
    task automatic step(input bit arst, input bit vr, input bit rv, input bit rr,
                        input logic [31:0] d, input bit pren, input bit dispon);
        bit          wr_ok;
        bit          pop_ok;
        logic [31:0] head;
        ARST = arst;
        VRSTART = vr;
        RVALID = rv;
        RREADY = rr;
        RDATA = d;
        DSP_PREN = pren;
        DISPON = dispon;
        @(posedge ACLK);
        if (!arst || vr) begin
            q.delete();
            m_uf = 0;
            m_of = 0;
            m_pix = '0;
            m_wr = 1;
            m_ufcnt = 0;
        end else begin
            wr_ok = rv && rr && (q.size() < DEPTH);
            pop_ok = pren && (q.size() > 0);
            if (pren && q.size() == 0) begin
                m_uf = 1;
                if (m_ufcnt < 65535)
                    m_ufcnt++;
            end
            if (rv && rr && q.size() == DEPTH)
                m_of = 1;
            m_pix = '0;
            if (pop_ok) begin
                head = q.pop_front();
                if (dispon)
                    m_pix = head[23:0];
            end
            if (wr_ok)
                q.push_back(d);
            m_wr = (DEPTH - q.size()) >= BURST;
        end
        live = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1, 0, 0, 0, '0, 0, 1);
    endtask

    task automatic wr(input logic [31:0] d);
        step(1, 0, 1, 1, d, 0, 1);
    endtask

    task automatic pop(input bit dispon);
        step(1, 0, 0, 0, '0, 1, dispon);
    endtask

    task automatic flush();
        step(1, 1, 0, 0, '0, 0, 1);
    endtask

    always @(negedge ACLK) begin
        if (live) begin
            chk("pixel", {8'h00, DSP_R, DSP_G, DSP_B}, {8'h00, m_pix});
            chk("wready", 32'(BUF_WREADY), 32'(m_wr));
            chk("underflow", 32'(BUF_UNDERFLOW), 32'(m_uf));
            chk("overflow", 32'(BUF_OVERFLOW), 32'(m_of));
`ifdef DISP_BUF_STAT_EN
            chk("ufcnt", 32'(BUF_UFCNT), 32'(m_ufcnt));
`endif
        end
    end

    initial begin
        int wp;
        int pp;
        step(0, 0, 0, 0, '0, 0, 0);
        step(0, 0, 0, 0, '0, 0, 0);
        idle(2);
        chk("lit_reset_wready", 32'(BUF_WREADY), 32'd1);
        chk("lit_reset_rgb", {8'h00, DSP_R, DSP_G, DSP_B}, 32'h0);
        chk("lit_reset_uf", 32'(BUF_UNDERFLOW), 32'd0);

        wr(32'hFFAABBCC);
        for (int i = 1; i < 64; i++)
            wr($urandom);
        pop(1);
        chk("lit_first_r", 32'(DSP_R), 32'hAA);
        chk("lit_first_g", 32'(DSP_G), 32'hBB);
        chk("lit_first_b", 32'(DSP_B), 32'hCC);
        for (int i = 1; i < 64; i++)
            pop(1);
        idle(1);
        chk("lit_drain_uf", 32'(BUF_UNDERFLOW), 32'd0);
        chk("lit_drain_rgb", {8'h00, DSP_R, DSP_G, DSP_B}, 32'h0);

        flush();
        for (int i = 0; i < 449; i++)
            wr($urandom);
        chk("lit_449_wready", 32'(BUF_WREADY), 32'd0);
        pop(1);
        chk("lit_448_wready", 32'(BUF_WREADY), 32'd1);
        for (int i = 0; i < 64; i++)
            wr($urandom);
        chk("lit_full_of", 32'(BUF_OVERFLOW), 32'd0);
        wr(32'h00123456);
        chk("lit_over_of", 32'(BUF_OVERFLOW), 32'd1);
        step(1, 0, 1, 1, 32'h00654321, 1, 1);
        chk("lit_full_wp_of", 32'(BUF_OVERFLOW), 32'd1);
        flush();
        chk("lit_flush_of", 32'(BUF_OVERFLOW), 32'd0);
        chk("lit_flush_wready", 32'(BUF_WREADY), 32'd1);

        for (int i = 0; i < 3; i++)
            pop(1);
        chk("lit_empty_uf", 32'(BUF_UNDERFLOW), 32'd1);
        chk("lit_empty_rgb", {8'h00, DSP_R, DSP_G, DSP_B}, 32'h0);
`ifdef DISP_BUF_STAT_EN
        chk("lit_ufcnt3", 32'(BUF_UFCNT), 32'd3);
`endif
        flush();
        for (int i = 0; i < 10; i++)
            wr($urandom);
        step(1, 0, 1, 1, 32'h00010203, 1, 1);
        step(1, 1, 1, 1, 32'h00DEAD01, 1, 1);
        chk("lit_vr_rgb", {8'h00, DSP_R, DSP_G, DSP_B}, 32'h0);
        pop(1);
        chk("lit_vr_discard_uf", 32'(BUF_UNDERFLOW), 32'd1);
        for (int i = 0; i < 5; i++)
            wr($urandom);
        step(0, 0, 1, 1, 32'h00BEEF00, 1, 1);
        chk("lit_arst_uf", 32'(BUF_UNDERFLOW), 32'd0);
        pop(0);
        chk("lit_arst_pop_uf", 32'(BUF_UNDERFLOW), 32'd1);

        wp = 60;
        pp = 40;
        for (int c = 0; c < 5000; c++) begin
            if (c % 400 == 0) begin
                wp = $urandom_range(20, 95);
                pp = $urandom_range(10, 90);
            end
            step(($urandom_range(0, 699) != 0),
                 ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < wp),
                 ($urandom_range(0, 99) < 85),
                 $urandom,
                 ($urandom_range(0, 99) < pp),
                 ($urandom_range(0, 9) != 0));
        end
        idle(2);
        live = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
